// File: rtl/seg_pattern_encoder.sv
// Debounces an active-low seven-segment bus and encodes the glyphs 'd', 'E', '1' and blank
// back to 2-bit codes, flagging illegal patterns and spotting the accepted sequence d,E,1.
module seg_pattern_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [6:0]       HEX_IN,
    output logic [1:0]       sym_code,
    output logic             sym_valid,
    output logic             sym_illegal,
    output logic             seq_hit,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] CODE_D     = 2'b00;
    localparam logic [1:0] CODE_E     = 2'b01;
    localparam logic [1:0] CODE_ONE   = 2'b10;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_D    = 2'b01,
        S_DE   = 2'b10
    } seq_state_t;

    // Returns {legal, code}; code is don't-care (blank) when illegal.
    function automatic logic [2:0] encode_glyph(input logic [6:0] pat);
        logic [2:0] res;
        case (pat)
            7'b0100001: res = {1'b1, CODE_D};
            7'b0000110: res = {1'b1, CODE_E};
            7'b1111001: res = {1'b1, CODE_ONE};
            7'b1111111: res = {1'b1, CODE_BLANK};
            default:    res = {1'b0, CODE_BLANK};
        endcase
        return res;
    endfunction

    logic [6:0]       s0_q, s0_d;
    logic [6:0]       acc_pat_q, acc_pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sym_code_q, sym_code_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_illegal_q, sym_illegal_d;
    logic             seq_hit_q, seq_hit_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    seq_state_t       state_q, state_d;

    logic             accept_s;
    logic             legal_s;
    logic [1:0]       code_s;

    // Sample/debounce stage and acceptance of a newly stable pattern.
    always_comb begin
        s0_d          = HEX_IN;
        cnt_d         = cnt_q;
        acc_pat_d     = acc_pat_q;
        sym_code_d    = sym_code_q;
        sym_valid_d   = 1'b0;
        sym_illegal_d = 1'b0;
        err_cnt_d     = err_cnt_q;
        {legal_s, code_s} = encode_glyph(s0_q);
        accept_s      = (cnt_q == CNT_MAX) && (s0_q != acc_pat_q);

        if (HEX_IN != s0_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        if (accept_s) begin
            acc_pat_d = s0_q;
            if (legal_s) begin
                sym_code_d  = code_s;
                sym_valid_d = 1'b1;
            end else begin
                sym_illegal_d = 1'b1;
                if (err_cnt_q != {ERR_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end
        end else begin
            acc_pat_d = acc_pat_q;
        end
    end

    // Sequence tracker: moves only on acceptances; blank is transparent, illegal aborts.
    always_comb begin
        state_d   = state_q;
        seq_hit_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && legal_s && (code_s == CODE_D)) begin
                    state_d = S_D;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_D: begin
                if (!accept_s) begin
                    state_d = S_D;
                end else if (!legal_s) begin
                    state_d = S_IDLE;
                end else begin
                    case (code_s)
                        CODE_E:     state_d = S_DE;
                        CODE_D:     state_d = S_D;
                        CODE_BLANK: state_d = S_D;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            S_DE: begin
                if (!accept_s) begin
                    state_d = S_DE;
                end else if (!legal_s) begin
                    state_d = S_IDLE;
                end else begin
                    case (code_s)
                        CODE_ONE: begin
                            state_d   = S_IDLE;
                            seq_hit_d = 1'b1;
                        end
                        CODE_D:     state_d = S_D;
                        CODE_BLANK: state_d = S_DE;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s0_q          <= 7'h7F;
            acc_pat_q     <= 7'h7F;
            cnt_q         <= {CNT_W{1'b0}};
            sym_code_q    <= CODE_BLANK;
            sym_valid_q   <= 1'b0;
            sym_illegal_q <= 1'b0;
            seq_hit_q     <= 1'b0;
            err_cnt_q     <= {ERR_W{1'b0}};
            state_q       <= S_IDLE;
        end else begin
            s0_q          <= s0_d;
            acc_pat_q     <= acc_pat_d;
            cnt_q         <= cnt_d;
            sym_code_q    <= sym_code_d;
            sym_valid_q   <= sym_valid_d;
            sym_illegal_q <= sym_illegal_d;
            seq_hit_q     <= seq_hit_d;
            err_cnt_q     <= err_cnt_d;
            state_q       <= state_d;
        end
    end

    assign sym_code    = sym_code_q;
    assign sym_valid   = sym_valid_q;
    assign sym_illegal = sym_illegal_q;
    assign seq_hit     = seq_hit_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Directed bench for seg_pattern_encoder: a default instance plus an ERR_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_seg_pattern_encoder;

    localparam logic [6:0] P_D     = 7'b0100001;
    localparam logic [6:0] P_E     = 7'b0000110;
    localparam logic [6:0] P_ONE   = 7'b1111001;
    localparam logic [6:0] P_BLANK = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] hex_in;
    logic [1:0] sym_code, sym_code2;
    logic       sym_valid, sym_valid2;
    logic       sym_illegal, sym_illegal2;
    logic       seq_hit, seq_hit2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int checks = 0;
    int errors = 0;
    int n_valid, n_illegal, n_hit, n_both;

    seg_pattern_encoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .CLOCK_50(clk), .reset(reset), .HEX_IN(hex_in),
        .sym_code(sym_code), .sym_valid(sym_valid), .sym_illegal(sym_illegal),
        .seq_hit(seq_hit), .err_cnt(err_cnt)
    );

    seg_pattern_encoder #(.STABLE_CYCLES(4), .ERR_W(2)) dut_sat (
        .CLOCK_50(clk), .reset(reset), .HEX_IN(hex_in),
        .sym_code(sym_code2), .sym_valid(sym_valid2), .sym_illegal(sym_illegal2),
        .seq_hit(seq_hit2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid = 0; n_illegal = 0; n_hit = 0; n_both = 0;
    endtask

    // One sampling edge with value v; outputs are observed 1 time unit after the edge.
    task automatic tick(input logic [6:0] v);
        hex_in = v;
        @(posedge clk);
        #1;
        if (sym_valid)   n_valid++;
        if (sym_illegal) n_illegal++;
        if (seq_hit)     n_hit++;
        if (sym_valid && sym_illegal) n_both++;
    endtask

    task automatic apply(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        reset  = 1'b1;
        hex_in = P_BLANK;
        clear_counts();
        apply(P_BLANK, 2);
        chk("rst_code",    32'(sym_code),    32'd3);
        chk("rst_valid",   32'(sym_valid),   32'd0);
        chk("rst_illegal", 32'(sym_illegal), 32'd0);
        chk("rst_hit",     32'(seq_hit),     32'd0);
        chk("rst_err",     32'(err_cnt),     32'd0);
        reset = 1'b0;

        // T1: blank after reset is never accepted
        clear_counts();
        apply(P_BLANK, 20);
        chk("t1_nvalid",   32'(n_valid),   32'd0);
        chk("t1_nillegal", 32'(n_illegal), 32'd0);
        chk("t1_code",     32'(sym_code),  32'd3);
        chk("t1_err",      32'(err_cnt),   32'd0);

        // T2: E held; pulse only after the fifth edge, exactly one cycle
        clear_counts();
        apply(P_E, 4);
        chk("t2_early",  32'(sym_valid), 32'd0);
        tick(P_E);
        chk("t2_valid",  32'(sym_valid), 32'd1);
        chk("t2_code",   32'(sym_code),  32'd1);
        tick(P_E);
        chk("t2_width",  32'(sym_valid), 32'd0);
        apply(P_E, 10);
        chk("t2_nvalid", 32'(n_valid),   32'd1);

        // T3: short 'd' glitch is discarded, '1' accepted once
        clear_counts();
        apply(P_D, 2);
        apply(P_ONE, 4);
        chk("t3_early",  32'(n_valid),   32'd0);
        tick(P_ONE);
        chk("t3_valid",  32'(sym_valid), 32'd1);
        chk("t3_code",   32'(sym_code),  32'd2);
        apply(P_ONE, 3);
        chk("t3_nvalid", 32'(n_valid),   32'd1);

        // T4: d, blank, E, 1 hits; seq_hit coincides with the '1' pulse
        clear_counts();
        apply(P_D, 5);
        apply(P_BLANK, 5);
        apply(P_E, 5);
        apply(P_ONE, 4);
        chk("t4_nvalid", 32'(n_valid),   32'd3);
        chk("t4_nohit",  32'(n_hit),     32'd0);
        tick(P_ONE);
        chk("t4_valid",  32'(sym_valid), 32'd1);
        chk("t4_hit",    32'(seq_hit),   32'd1);
        tick(P_ONE);
        chk("t4_hitw",   32'(seq_hit),   32'd0);
        clear_counts();
        apply(P_D, 5);
        apply(P_ONE, 5);
        chk("t4_d1_valid", 32'(n_valid), 32'd2);
        chk("t4_d1_hit",   32'(n_hit),   32'd0);

        // T5: illegal pattern, code holds, counters count/saturate
        clear_counts();
        apply(7'h00, 4);
        chk("t5_early",   32'(sym_illegal), 32'd0);
        tick(7'h00);
        chk("t5_illegal", 32'(sym_illegal), 32'd1);
        chk("t5_novalid", 32'(sym_valid),   32'd0);
        chk("t5_code",    32'(sym_code),    32'd2);
        chk("t5_err1",    32'(err_cnt),     32'd1);
        tick(7'h00);
        chk("t5_width",   32'(sym_illegal), 32'd0);
        apply(7'h01, 5);
        apply(7'h02, 5);
        apply(7'h03, 5);
        apply(7'h04, 5);
        chk("t5_nillegal", 32'(n_illegal), 32'd5);
        chk("t5_err5",     32'(err_cnt),   32'd5);
        chk("t5_sat",      32'(err_cnt2),  32'd3);

        // Illegal between d and E aborts the sequence
        clear_counts();
        apply(P_D, 5);
        apply(7'h05, 5);
        apply(P_E, 5);
        apply(P_ONE, 5);
        chk("abort_hit", 32'(n_hit),    32'd0);
        chk("abort_err", 32'(err_cnt),  32'd6);
        chk("abort_sat", 32'(err_cnt2), 32'd3);

        // Re-presenting the accepted pattern after a glitch gives no pulse
        clear_counts();
        apply(P_E, 2);
        apply(P_ONE, 10);
        chk("repr_valid",   32'(n_valid),   32'd0);
        chk("repr_illegal", 32'(n_illegal), 32'd0);
        chk("never_both",   32'(n_both),    32'd0);

        // T6: reset in the middle of a pending 'E' after an accepted 'd'
        apply(P_D, 5);
        apply(P_E, 3);
        reset = 1'b1;
        tick(P_E);
        chk("t6_code",    32'(sym_code),    32'd3);
        chk("t6_valid",   32'(sym_valid),   32'd0);
        chk("t6_illegal", 32'(sym_illegal), 32'd0);
        chk("t6_err",     32'(err_cnt),     32'd0);
        chk("t6_err2",    32'(err_cnt2),    32'd0);
        reset = 1'b0;
        clear_counts();
        apply(P_E, 4);
        chk("t6_early",   32'(n_valid),     32'd0);
        tick(P_E);
        chk("t6_valid2",  32'(sym_valid),   32'd1);
        chk("t6_code2",   32'(sym_code),    32'd1);
        apply(P_ONE, 5);
        chk("t6_nohit",   32'(n_hit),       32'd0);
        chk("t6_nvalid",  32'(n_valid),     32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
